// File: rtl/dms_pkg.sv
// Shared types and constants for the DMS low-pass-filter trim calibration block.
package dms_pkg;

  localparam int   DMS_TRIM_W    = 4;
  localparam int   DMS_SETTLE_CW = 10;
  localparam int   DMS_VOTE_CW   = 5;
  localparam logic DMS_CMP_HIGH  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_G_SET    = 3'd1,
    ST_G_SETTLE = 3'd2,
    ST_G_VOTE   = 3'd3,
    ST_P_SET    = 3'd4,
    ST_P_SETTLE = 3'd5,
    ST_P_VOTE   = 3'd6,
    ST_DONE     = 3'd7
  } dms_trim_cal_state_e;

  function automatic logic dms_cmp_hit(input logic cmp);
    return cmp == DMS_CMP_HIGH;
  endfunction

endpackage

// File: rtl/dms_settle_vote.sv
// Settle timer followed by a majority voter; go restarts it, decide marks the last vote cycle.
module dms_settle_vote
  import dms_pkg::*;
#(
  parameter int SETTLE_CYC = 64,
  parameter int VOTE_N     = 7
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic go,
  input  logic CMP,
  output logic settle_done,
  output logic decide,
  output logic majority
);

  if ((VOTE_N % 2) == 0 || VOTE_N < 1 || VOTE_N > 31) begin : g_bad_vote_n
    $error("dms_settle_vote: VOTE_N must be odd and within 1..31");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 1023) begin : g_bad_settle
    $error("dms_settle_vote: SETTLE_CYC must be within 1..1023");
  end

  localparam logic [DMS_SETTLE_CW-1:0] SETTLE_LAST = DMS_SETTLE_CW'(SETTLE_CYC - 1);
  localparam logic [DMS_VOTE_CW-1:0]   VOTE_LAST   = DMS_VOTE_CW'(VOTE_N - 1);
  localparam logic [DMS_VOTE_CW:0]     VOTE_HALF   = (DMS_VOTE_CW + 1)'(VOTE_N / 2);

  logic                     act_q, act_d;
  logic                     vote_q, vote_d;
  logic [DMS_SETTLE_CW-1:0] scnt_q, scnt_d;
  logic [DMS_VOTE_CW-1:0]   vcnt_q, vcnt_d;
  logic [DMS_VOTE_CW-1:0]   ones_q, ones_d;
  logic [DMS_VOTE_CW:0]     ones_tot;

  // The current CMP sample is folded in so the decision lands on the last vote cycle.
  assign ones_tot    = {1'b0, ones_q} + {{DMS_VOTE_CW{1'b0}}, dms_cmp_hit(CMP)};
  assign settle_done = act_q & ~vote_q & (scnt_q == SETTLE_LAST);
  assign decide      = act_q &  vote_q & (vcnt_q == VOTE_LAST);
  assign majority    = ones_tot > VOTE_HALF;

  always_comb begin
    act_d  = act_q;
    vote_d = vote_q;
    scnt_d = scnt_q;
    vcnt_d = vcnt_q;
    ones_d = ones_q;
    if (go) begin
      act_d  = 1'b1;
      vote_d = 1'b0;
      scnt_d = '0;
      vcnt_d = '0;
      ones_d = '0;
    end else if (settle_done) begin
      vote_d = 1'b1;
    end else if (act_q && !vote_q) begin
      scnt_d = scnt_q + DMS_SETTLE_CW'(1);
    end else if (decide) begin
      act_d = 1'b0;
    end else if (act_q) begin
      vcnt_d = vcnt_q + DMS_VOTE_CW'(1);
      ones_d = ones_tot[DMS_VOTE_CW-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      act_q  <= 1'b0;
      vote_q <= 1'b0;
      scnt_q <= '0;
      vcnt_q <= '0;
      ones_q <= '0;
    end else begin
      act_q  <= act_d;
      vote_q <= vote_d;
      scnt_q <= scnt_d;
      vcnt_q <= vcnt_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/dms_lpf_trim_cal.sv
// SAR calibration of the DMS LPF gain then pole trim codes from a voted comparator.
// Pole phase is built only with DMS_TRIM_CAL_POLE_EN defined; otherwise gain-only.
module dms_lpf_trim_cal
  import dms_pkg::*;
#(
  parameter int                    SETTLE_CYC   = 64,
  parameter int                    VOTE_N       = 7,
  parameter logic [DMS_TRIM_W-1:0] POLE_DEFAULT = 4'd4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  CMP,
  output logic                  STIM_SEL,
  output logic [DMS_TRIM_W-1:0] gainTrim,
  output logic [DMS_TRIM_W-1:0] poleTrim,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [1:0]            IDX_MSB  = 2'(DMS_TRIM_W - 1);
  localparam logic [DMS_TRIM_W-1:0] GAIN_RST = {1'b1, {(DMS_TRIM_W-1){1'b0}}};

  dms_trim_cal_state_e   state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [DMS_TRIM_W-1:0] gain_q, gain_d;
  logic                  go, settle_done, decide, majority;

`ifdef DMS_TRIM_CAL_POLE_EN
  logic [DMS_TRIM_W-1:0] pole_q, pole_d;
  logic                  stim_q, stim_d;
`endif

  assign go = (state_q == ST_G_SET) || (state_q == ST_P_SET);

  dms_settle_vote #(
    .SETTLE_CYC (SETTLE_CYC),
    .VOTE_N     (VOTE_N)
  ) u_settle_vote (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .go          (go),
    .CMP         (CMP),
    .settle_done (settle_done),
    .decide      (decide),
    .majority    (majority)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gain_d  = gain_q;
`ifdef DMS_TRIM_CAL_POLE_EN
    pole_d  = pole_q;
    stim_d  = stim_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_G_SET;
          gain_d  = '0;
          idx_d   = IDX_MSB;
`ifdef DMS_TRIM_CAL_POLE_EN
          pole_d  = POLE_DEFAULT;
`endif
        end
      end
      ST_G_SET: begin
        gain_d[idx_q] = 1'b1;
        state_d       = ST_G_SETTLE;
      end
      ST_G_SETTLE: if (settle_done) state_d = ST_G_VOTE;
      ST_G_VOTE: begin
        if (decide) begin
          if (majority) gain_d[idx_q] = 1'b0;
          if (idx_q != 2'd0) begin
            idx_d   = idx_q - 2'd1;
            state_d = ST_G_SET;
          end else begin
`ifdef DMS_TRIM_CAL_POLE_EN
            // Stimulus flips here so the first pole settle window absorbs it.
            state_d = ST_P_SET;
            idx_d   = IDX_MSB;
            pole_d  = '0;
            stim_d  = 1'b1;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef DMS_TRIM_CAL_POLE_EN
      ST_P_SET: begin
        pole_d[idx_q] = 1'b1;
        state_d       = ST_P_SETTLE;
      end
      ST_P_SETTLE: if (settle_done) state_d = ST_P_VOTE;
      ST_P_VOTE: begin
        if (decide) begin
          if (majority) pole_d[idx_q] = 1'b0;
          if (idx_q != 2'd0) begin
            idx_d   = idx_q - 2'd1;
            state_d = ST_P_SET;
          end else begin
            state_d = ST_DONE;
            stim_d  = 1'b0;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_MSB;
      gain_q  <= GAIN_RST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gain_q  <= gain_d;
    end
  end

`ifdef DMS_TRIM_CAL_POLE_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pole_q <= POLE_DEFAULT;
      stim_q <= 1'b0;
    end else begin
      pole_q <= pole_d;
      stim_q <= stim_d;
    end
  end
  assign poleTrim = pole_q;
  assign STIM_SEL = stim_q;
`else
  assign poleTrim = POLE_DEFAULT;
  assign STIM_SEL = 1'b0;
`endif

  assign gainTrim = gain_q;
  assign BUSY     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign DONE     = (state_q == ST_DONE);

endmodule
